// File: rtl/control_decodificador_if.sv
// Handshake and result bus of the SECDED (8,4) receive controller.
//   slave  : the controller (consumes the word, produces the result)
//   master : the producer/consumer around it (testbench, upstream, display)
//   in_valid/in_ready/palabra_rx    : received-word handshake
//   out_valid/out_ready             : result handshake
//   dato/pos_error/error_*          : decoded result, held until acknowledged
interface control_decodificador_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] palabra_rx;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] dato;
  logic [3:0] pos_error;
  logic       error_simple;
  logic       error_doble;

  modport master (
    output in_valid, palabra_rx, out_ready,
    input  in_ready, out_valid, dato, pos_error, error_simple, error_doble
  );

  modport slave (
    input  in_valid, palabra_rx, out_ready,
    output in_ready, out_valid, dato, pos_error, error_simple, error_doble
  );
endinterface

// File: rtl/control_decodificador.sv
// SECDED (8,4) receive sequencer: capture -> syndrome -> correct -> present.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   bus (slave)     : word in, result out, both with valid/ready
//   cnt_clr         : clears both statistics counters (wins over increments)
//   cnt_corregidos  : saturating count of corrected single errors
//   cnt_dobles      : saturating count of detected double errors
//   ocupado         : high whenever the FSM is not in IDLE
// Word layout, bit 7..0: g0 w3 w2 w1 p2 w0 p1 p0 (Hamming position k = bit k-1).
module control_decodificador #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  control_decodificador_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_corregidos,
  output logic [CNT_W-1:0]     cnt_dobles,
  output logic                 ocupado
);

  typedef enum logic [1:0] {IDLE, SINDROME, CORRIGE, PRESENTA} state_t;

  state_t     state;
  logic [7:0] cap;

  // {eg, e2, e1, e0} of the captured word
  logic [3:0] sind;
  assign sind = {^cap,
                 cap[3] ^ cap[4] ^ cap[5] ^ cap[6],
                 cap[1] ^ cap[2] ^ cap[5] ^ cap[6],
                 cap[0] ^ cap[2] ^ cap[4] ^ cap[6]};

  // Correction works on the syndrome already registered in pos_error.
  logic [2:0] s;
  logic       eg;
  logic       es_simple;
  logic       es_doble;
  logic [7:0] mask;
  logic [7:0] fixed;

  assign s         = bus.pos_error[2:0];
  assign eg        = bus.pos_error[3];
  assign es_simple = eg;
  assign es_doble  = !eg && (s != 3'd0);

  // Only flip when a data/check position is named; eg=1 with s=0 means g0 itself
  // was hit and the payload is already good. In the double case the result is
  // forced to zero anyway, so the mask value does not matter there.
  always_comb begin
    mask = '0;
    if (s != 3'd0) mask[s - 3'd1] = 1'b1;
    fixed = cap ^ mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cap              <= '0;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.dato         <= '0;
      bus.pos_error    <= '0;
      bus.error_simple <= 1'b0;
      bus.error_doble  <= 1'b0;
      ocupado          <= 1'b0;
      cnt_corregidos   <= '0;
      cnt_dobles       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cap          <= bus.palabra_rx;
            bus.in_ready <= 1'b0;
            ocupado      <= 1'b1;
            state        <= SINDROME;
          end
        end
        SINDROME: begin
          bus.pos_error <= sind;
          state         <= CORRIGE;
        end
        CORRIGE: begin
          bus.dato         <= es_doble ? 4'b0000 : {fixed[6], fixed[5], fixed[4], fixed[2]};
          bus.error_simple <= es_simple;
          bus.error_doble  <= es_doble;
          bus.out_valid    <= 1'b1;
          state            <= PRESENTA;
        end
        PRESENTA: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            ocupado       <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          ocupado       <= 1'b0;
          state         <= IDLE;
        end
      endcase

      // Counters only advance in CORRIGE, so a held word is counted once.
      if (cnt_clr) begin
        cnt_corregidos <= '0;
        cnt_dobles     <= '0;
      end else if (state == CORRIGE) begin
        if (es_simple && (cnt_corregidos != '1)) cnt_corregidos <= cnt_corregidos + CNT_W'(1);
        if (es_doble  && (cnt_dobles     != '1)) cnt_dobles     <= cnt_dobles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_control_decodificador.sv
// Randomized self-checking bench for control_decodificador.
module tb_control_decodificador;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_corregidos;
  logic [CNT_W-1:0] cnt_dobles;
  logic             ocupado;

  control_decodificador_if bus_if();

  control_decodificador #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_if),
    .cnt_clr        (cnt_clr),
    .cnt_corregidos (cnt_corregidos),
    .cnt_dobles     (cnt_dobles),
    .ocupado        (ocupado)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_ok  = 0;
  int last_hs = -100;
  int exp_corr = 0;
  int exp_dob  = 0;
  logic [3:0] exp_dato = '0;
  logic [3:0] exp_pos  = '0;
  logic       exp_es   = 1'b0;
  logic       exp_ed   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Syndrome = XOR of positions of set bits; eg = overall parity.
  function automatic logic [9:0] ref_model(input logic [7:0] w);
    int s;
    bit eg, es, ed;
    logic [7:0] c;
    logic [3:0] d;
    s = 0;
    for (int k = 1; k <= 7; k++) if (w[k-1]) s ^= k;
    eg = ($countones(w) % 2) == 1;
    c = w; es = 0; ed = 0;
    if (eg) begin
      es = 1;
      if (s != 0) c[s-1] = ~c[s-1];
    end else if (s != 0) ed = 1;
    d = ed ? 4'b0000 : {c[6], c[5], c[4], c[2]};
    return {ed, es, d, eg, s[2:0]};
  endfunction

  task automatic chk_result(input string pfx);
    chk({pfx, "_dato"}, 32'(bus_if.dato), 32'(exp_dato));
    chk({pfx, "_pos"},  32'(bus_if.pos_error), 32'(exp_pos));
    chk({pfx, "_es"},   32'(bus_if.error_simple), 32'(exp_es));
    chk({pfx, "_ed"},   32'(bus_if.error_doble), 32'(exp_ed));
    chk({pfx, "_ccorr"}, 32'(cnt_corregidos), exp_corr);
    chk({pfx, "_cdob"},  32'(cnt_dobles), exp_dob);
  endtask

  // One full transaction; called at a negedge, returns at the negedge after release.
  task automatic do_word(input logic [7:0] w, input int stall, input bit clr_corr, input bit b2b);
    int t;
    int hs;
    logic [9:0] r;
    t = 0;
    while (!bus_if.in_ready && t < 20) begin @(negedge clk); t++; end
    chk("in_ready_wait", 32'(bus_if.in_ready), 1);
    bus_if.in_valid   = 1'b1;
    bus_if.palabra_rx = w;
    @(negedge clk);                       // SINDROME
    hs = cyc;
    if (b2b) chk("throughput", hs - last_hs, 4);
    last_hs = hs;
    // Traffic while busy must be ignored.
    bus_if.in_valid   = 1'($urandom);
    bus_if.palabra_rx = 8'h55;
    chk("ov_sind", 32'(bus_if.out_valid), 0);
    chk("ir_sind", 32'(bus_if.in_ready), 0);
    chk("busy", 32'(ocupado), 1);
    bus_if.out_ready = 1'($urandom);
    @(negedge clk);                       // CORRIGE
    chk("ov_corr", 32'(bus_if.out_valid), 0);
    cnt_clr          = clr_corr;
    bus_if.out_ready = 1'($urandom);
    @(negedge clk);                       // PRESENTA
    cnt_clr = 1'b0;
    r = ref_model(w);
    {exp_ed, exp_es, exp_dato, exp_pos} = r;
    if (clr_corr) begin
      exp_corr = 0;
      exp_dob  = 0;
    end else begin
      if (exp_es && exp_corr < CMAX) exp_corr++;
      if (exp_ed && exp_dob  < CMAX) exp_dob++;
    end
    chk("ov_lat", 32'(bus_if.out_valid), 1);
    chk_result("res");
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      bus_if.in_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_ov", 32'(bus_if.out_valid), 1);
      chk("hold_ir", 32'(bus_if.in_ready), 0);
      chk_result("hold");
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);                       // back in IDLE
    bus_if.out_ready = 1'b0;
    chk("ov_drop", 32'(bus_if.out_valid), 0);
    chk("ir_back", 32'(bus_if.in_ready), 1);
    chk("idle", 32'(ocupado), 0);
    chk_result("kept");
  endtask

  initial begin
    int prev_stall;
    int st;
    rst = 1'b1;
    cnt_clr = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.palabra_rx = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ir", 32'(bus_if.in_ready), 1);
    chk("rst_ov", 32'(bus_if.out_valid), 0);
    chk("rst_busy", 32'(ocupado), 0);
    chk_result("rst");

    // Directed classes
    do_word(8'h55, 0, 0, 0);
    do_word(8'h45, 0, 0, 1);
    do_word(8'hD5, 0, 0, 1);
    do_word(8'h44, 0, 0, 1);
    // Backpressure, then a different word must be the next one decoded
    do_word(8'h45, 3, 0, 1);
    do_word(8'h44, 0, 0, 0);

    // Random words, stalls and occasional clear in CORRIGE
    prev_stall = 0;
    for (int i = 0; i < 40; i++) begin
      st = $urandom_range(0, 2);
      do_word(8'($urandom), st, ($urandom % 8) == 0, prev_stall == 0);
      prev_stall = st;
    end

    // Clear from IDLE
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_corr = 0;
    exp_dob  = 0;
    chk("clr_idle_c", 32'(cnt_corregidos), 0);
    chk("clr_idle_d", 32'(cnt_dobles), 0);

    // Saturation
    for (int i = 0; i < 256; i++) do_word(8'h45, 0, 0, i != 0);
    chk("sat", 32'(cnt_corregidos), 255);
    do_word(8'h45, 0, 1, 1);
    chk("clr_wins", 32'(cnt_corregidos), 0);

    // Make counters nonzero, then reset during SINDROME
    do_word(8'h44, 0, 0, 0);
    bus_if.in_valid = 1'b1;
    bus_if.palabra_rx = 8'h45;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_corr = 0; exp_dob = 0;
    exp_dato = '0; exp_pos = '0; exp_es = 1'b0; exp_ed = 1'b0;
    chk("mrst_ir", 32'(bus_if.in_ready), 1);
    chk("mrst_busy", 32'(ocupado), 0);
    chk_result("mrst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_noov", 32'(bus_if.out_valid), 0);
    end

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
